// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU by shift-add, DIV/DIVU by restoring division.
// Optional macro MDU_FAST_MUL_EN switches MULT/MULTU to a single-cycle combinational multiplier.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc, acc_step, mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               is_div, raw, neg_res, neg_dvd, last;

  logic             sgn, a_neg, b_neg, dz;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_abs = a_neg ? -a : a;
    b_abs = b_neg ? -b : b;
    dz    = op[1] & (b == '0);
  end

  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff, rem_nx, q_res, r_res;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    mul_nx  = {sum, acc[WIDTH-1:1]};
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = shifted >= {1'b0, m};
    // the true difference is below m whenever ge holds, so WIDTH bits suffice
    diff    = shifted[WIDTH-1:0] - m;
    rem_nx  = ge ? diff : shifted[WIDTH-1:0];
    div_nx  = {rem_nx, acc[WIDTH-2:0], ge};
    acc_step = raw ? acc : (is_div ? div_nx : mul_nx);
    prod    = neg_res ? -acc_step : acc_step;
    q_res   = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    r_res   = neg_dvd ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    last    = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      acc     <= '0;
      m       <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      raw     <= 1'b0;
      neg_res <= 1'b0;
      neg_dvd <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          is_div  <= op[1];
          neg_res <= a_neg ^ b_neg;
          neg_dvd <= a_neg;
          raw     <= 1'b0;
          cnt     <= '0;
          if (dz) begin
            // divide by zero: result is final, finish on the next edge
            acc <= {a, {WIDTH{1'b1}}};
            raw <= 1'b1;
            cnt <= CW'(WIDTH-1);
          end else if (op[1]) begin
            acc <= {{WIDTH{1'b0}}, a_abs};
            m   <= b_abs;
          end else begin
`ifdef MDU_FAST_MUL_EN
            acc <= (a_neg ^ b_neg) ? -((2*WIDTH)'(a_abs) * (2*WIDTH)'(b_abs))
                                   :   (2*WIDTH)'(a_abs) * (2*WIDTH)'(b_abs);
            raw <= 1'b1;
            cnt <= CW'(WIDTH-1);
`else
            acc <= {{WIDTH{1'b0}}, b_abs};
            m   <= a_abs;
`endif
          end
        end else begin
          if (mthi) hi <= a;
          if (mtlo) lo <= a;
        end
      end else begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          if (raw) begin
            hi <= acc_step[2*WIDTH-1:WIDTH];
            lo <= acc_step[WIDTH-1:0];
          end else if (is_div) begin
            hi <= r_res;
            lo <= q_res;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
  logic        clk = 1'b0, rst, start, mthi, mtlo, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  int npass = 0, nfail = 0, ntot = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic verify(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int exp_lat);
    int lat, bc;
    run_op(o, x, y, lat, bc);
    chk({tag, " result"}, {hi, lo}, exp);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(bc), 64'(exp_lat));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk) rst = 1'b0;

    // preload HI so the dropped/ignored moves are observable
    @(negedge clk); mthi = 1'b1; a = 32'h1111_1111;
    @(posedge clk); #1 mthi = 1'b0;
    chk("mthi", 64'(hi), 64'h1111_1111);

    // start and mthi on the same edge: start wins
    @(negedge clk); op = 2'd1; a = 32'd5; b = 32'd6; start = 1'b1; mthi = 1'b1;
    @(posedge clk); #1 start = 1'b0; mthi = 1'b0;
    chk("start accepted", 64'(busy), 64'd1);
    chk("mthi dropped on start", 64'(hi), 64'h1111_1111);
    repeat (9) @(posedge clk);
    @(negedge clk); op = 2'd2; a = 32'hDEAD_BEEF; b = 32'd3; start = 1'b1; mthi = 1'b1;
    @(posedge clk); #1 start = 1'b0; mthi = 1'b0;
    lat = 10;
    chk("busy after ignored start", 64'(busy), 64'd1);
    chk("hi held in run", 64'(hi), 64'h1111_1111);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignored ops result", {hi, lo}, 64'h0000_0000_0000_001E);
    chk("ignored ops latency", 64'(lat), 64'(MUL_LAT));

    // reset in the middle of a divide
    @(negedge clk); op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0; mtlo = 1'b1; a = 32'h0000_00AA;
    @(posedge clk); #1 mtlo = 1'b0;
    chk("mtlo after reset", {hi, lo}, 64'h0000_0000_0000_00AA);

    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; a = 32'h5A5A_A5A5;
    @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
    chk("mthi+mtlo", {hi, lo}, 64'h5A5A_A5A5_5A5A_A5A5);

    verify("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT);
    verify("mult neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    verify("div neg dividend", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 32);
    verify("div neg divisor", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 32);
    verify("divu", 2'd3, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 32);
    verify("divu by zero", 2'd3, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF, 1);
    verify("div by zero", 2'd2, 32'h8765_4321, 32'h0, 64'h8765_4321_FFFF_FFFF, 1);
    verify("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      verify($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb),
             (ro[1] && rb == 0) ? 1 : (ro[1] ? 32 : MUL_LAT));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
